controller_data_ram_dp: RTL and testbench



---
 rtl/controller_data_ram_dp.sv | 137 +++++++++++++
 tb/tb_controller_data_ram_dp.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_data_ram_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// controller_data_ram_dp : true-dual-port Avalon-MM data RAM with optional
// post-reset zero-fill, pipelined reads and per-lane write arbitration.
// Revision: 1.0
// ---------------------------------------------------------------------------
module controller_data_ram_dp #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int PRIORITY_S2    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    waitrequest2,
  output logic                    collision
);

  localparam int N  = 2**ADDR_WIDTH;
  localparam int NB = DATA_WIDTH/8;

  typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [N];

  logic                    run, wr1, wr2, rd1, rd2, same_word;
  logic [NB-1:0]           lanes1, lanes2;

  logic [DATA_WIDTH-1:0]   pd1 [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pd2 [READ_LATENCY];
  logic [READ_LATENCY-1:0] pv1, pv2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    waitrequest  = 1'b0;
    waitrequest2 = 1'b0;
    if (state == CLEAR) begin
      waitrequest  = 1'b1;
      waitrequest2 = 1'b1;
      if (&clr_cnt) state_next = RUN;
    end
  end

  // Host traffic is only accepted while running and out of reset.
  always_comb begin
    run       = (state == RUN) && !reset;
    wr1       = run && chipselect && write;
    wr2       = run && chipselect2 && write2;
    rd1       = run && chipselect && read && !write;
    rd2       = run && chipselect2 && read2 && !write2;
    same_word = wr1 && wr2 && (address == address2);
    lanes1    = wr1 ? byteenable : '0;
    lanes2    = wr2 ? byteenable2 : '0;
    // On a same-word collision the losing port drops its overlapping lanes.
    if (same_word) begin
      if (PRIORITY_S2 != 0) lanes1 = lanes1 & ~byteenable2;
      else                  lanes2 = lanes2 & ~byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (lanes1[b]) mem[address][b*8 +: 8]  <= writedata[b*8 +: 8];
        if (lanes2[b]) mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
      end
    end
  end

  // Read data pipeline; memory sampled before this edge's writes land (old data).
  always_ff @(posedge clk) begin
    pd1[0] <= mem[address];
    pd2[0] <= mem[address2];
    for (int i = 1; i < READ_LATENCY; i++) begin
      pd1[i] <= pd1[i-1];
      pd2[i] <= pd2[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv1            <= '0;
      pv2            <= '0;
      readdata       <= '0;
      readdata2      <= '0;
      readdatavalid  <= 1'b0;
      readdatavalid2 <= 1'b0;
      collision      <= 1'b0;
    end else begin
      pv1[0] <= rd1;
      pv2[0] <= rd2;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv1[i] <= pv1[i-1];
        pv2[i] <= pv2[i-1];
      end
      readdatavalid  <= pv1[READ_LATENCY-1];
      readdatavalid2 <= pv2[READ_LATENCY-1];
      if (pv1[READ_LATENCY-1]) readdata  <= pd1[READ_LATENCY-1];
      if (pv2[READ_LATENCY-1]) readdata2 <= pd2[READ_LATENCY-1];
      collision <= same_word;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controller_data_ram_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_controller_data_ram_dp : directed checks on two configurations sharing
// stimulus (A: latency 2, zero-fill, s1 priority; B: latency 1, no fill, s2 priority).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_controller_data_ram_dp;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  address, address2;
  logic [3:0]  byteenable, byteenable2;
  logic        chipselect, chipselect2, read, read2, write, write2;
  logic [31:0] writedata, writedata2;

  logic [31:0] rd_a, rd2_a, rd_b, rd2_b;
  logic        rdv_a, rdv2_a, rdv_b, rdv2_b;
  logic        wr_a, wr2_a, wr_b, wr2_b, col_a, col_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  controller_data_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2),
                           .CLEAR_ON_RESET(1), .PRIORITY_S2(0)) dut_a (
    .clk(clk), .reset(reset),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(rd_a), .readdatavalid(rdv_a), .waitrequest(wr_a),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .read2(read2), .write2(write2), .writedata2(writedata2),
    .readdata2(rd2_a), .readdatavalid2(rdv2_a), .waitrequest2(wr2_a),
    .collision(col_a)
  );

  controller_data_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1),
                           .CLEAR_ON_RESET(0), .PRIORITY_S2(1)) dut_b (
    .clk(clk), .reset(reset),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata),
    .readdata(rd_b), .readdatavalid(rdv_b), .waitrequest(wr_b),
    .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
    .read2(read2), .write2(write2), .writedata2(writedata2),
    .readdata2(rd2_b), .readdatavalid2(rdv2_b), .waitrequest2(wr2_b),
    .collision(col_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 0; read = 0; write = 0; address = 0; byteenable = 0; writedata = 0;
    chipselect2 = 0; read2 = 0; write2 = 0; address2 = 0; byteenable2 = 0; writedata2 = 0;
  endtask

  task automatic wrq(input int p, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    if (p == 1) begin
      chipselect = 1; write = 1; address = a; writedata = d; byteenable = be;
    end else begin
      chipselect2 = 1; write2 = 1; address2 = a; writedata2 = d; byteenable2 = be;
    end
  endtask

  task automatic rdq(input int p, input logic [7:0] a);
    if (p == 1) begin
      chipselect = 1; read = 1; address = a; byteenable = 4'hF;
    end else begin
      chipselect2 = 1; read2 = 1; address2 = a; byteenable2 = 4'hF;
    end
  endtask

  // Accept the currently driven requests, then look for the read response on
  // port p of both instances: A must answer 2 cycles later, B 1 cycle later.
  task automatic collect(input int p, input string tag, input logic [31:0] ea,
                         input logic chk_b, input logic [31:0] eb);
    int lat_a = 0, lat_b = 0, cnt_a = 0, cnt_b = 0;
    logic [31:0] da = '0, db = '0;
    logic va, vb;
    step();
    idle();
    for (int c = 1; c <= 4; c++) begin
      step();
      va = (p == 1) ? rdv_a : rdv2_a;
      vb = (p == 1) ? rdv_b : rdv2_b;
      if (va) begin
        cnt_a++;
        if (lat_a == 0) begin lat_a = c; da = (p == 1) ? rd_a : rd2_a; end
      end
      if (vb) begin
        cnt_b++;
        if (lat_b == 0) begin lat_b = c; db = (p == 1) ? rd_b : rd2_b; end
      end
    end
    check($sformatf("%s_lat_a", tag), 64'({lat_a[7:0], cnt_a[7:0]}), 64'h0201);
    check($sformatf("%s_data_a", tag), 64'(da), 64'(ea));
    if (chk_b) begin
      check($sformatf("%s_lat_b", tag), 64'({lat_b[7:0], cnt_b[7:0]}), 64'h0101);
      check($sformatf("%s_data_b", tag), 64'(db), 64'(eb));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nv;
    logic [31:0] acc;
    logic [4:0] v1a, v2a, v1b, v2b;
    logic [31:0] d1a [5];
    logic [31:0] d2a [5];
    logic [31:0] d1b [5];
    logic [31:0] d2b [5];

    idle();
    reset = 1;
    step();
    step();
    check("rst_wait_a", 64'({wr_a, wr2_a}), 64'h3);
    check("rst_valid_col_a", 64'({rdv_a, rdv2_a, col_a}), 64'h0);
    check("rst_rdata_a", {rd_a, rd2_a}, 64'h0);
    check("rst_wait_b", 64'({wr_b, wr2_b, col_b}), 64'h0);

    // Zero-fill: a host write issued mid-clear must be ignored by A only.
    reset = 0;
    cnt = 0;
    while (wr_a && cnt < 1000) begin
      if (cnt == 100) wrq(1, 8'h05, 32'h5555AAAA, 4'hF);
      step();
      idle();
      cnt++;
    end
    check("clear_len", 64'(cnt), 64'd256);
    check("clear_wait2", 64'(wr2_a), 64'h0);

    acc = '0;
    nv = 0;
    for (int i = 0; i < 260; i++) begin
      if (i < 256) rdq(1, 8'(i)); else idle();
      step();
      if (rdv_a) begin nv++; acc = acc | rd_a; end
    end
    idle();
    check("clear_nvalid", 64'(nv), 64'd256);
    check("clear_zero", 64'(acc), 64'h0);

    rdq(1, 8'h05);
    collect(1, "ignored_wr", 32'h0, 1'b1, 32'h5555AAAA);

    // Independent writes to different words, then interleaved pipelined reads.
    wrq(1, 8'h10, 32'hDEADBEEF, 4'hF);
    wrq(2, 8'h11, 32'hCAFEF00D, 4'hF);
    step();
    idle();
    check("nocol", 64'({col_a, col_b}), 64'h0);
    for (int s = 0; s < 5; s++) begin
      idle();
      if (s == 0) begin rdq(1, 8'h10); rdq(2, 8'h11); end
      if (s == 1) begin rdq(1, 8'h11); rdq(2, 8'h10); end
      step();
      v1a[s] = rdv_a; v2a[s] = rdv2_a; v1b[s] = rdv_b; v2b[s] = rdv2_b;
      d1a[s] = rd_a; d2a[s] = rd2_a; d1b[s] = rd_b; d2b[s] = rd2_b;
    end
    idle();
    check("pipe_valid_a", 64'({v1a, v2a}), 64'({5'b01100, 5'b01100}));
    check("pipe_valid_b", 64'({v1b, v2b}), 64'({5'b00110, 5'b00110}));
    check("pipe_d1_a", {d1a[2], d1a[3]}, {32'hDEADBEEF, 32'hCAFEF00D});
    check("pipe_d2_a", {d2a[2], d2a[3]}, {32'hCAFEF00D, 32'hDEADBEEF});
    check("pipe_d1_b", {d1b[1], d1b[2]}, {32'hDEADBEEF, 32'hCAFEF00D});
    check("pipe_d2_b", {d2b[1], d2b[2]}, {32'hCAFEF00D, 32'hDEADBEEF});
    check("pipe_hold_a", {d1a[4], d2a[4]}, {32'hCAFEF00D, 32'hDEADBEEF});

    // Byte enables.
    wrq(1, 8'h20, 32'h11223344, 4'hF);
    step();
    idle();
    wrq(1, 8'h20, 32'hAABBCCDD, 4'b0101);
    step();
    idle();
    rdq(2, 8'h20);
    collect(2, "byteen", 32'h11BB33DD, 1'b1, 32'h11BB33DD);

    // Mixed-port read-during-write returns old data.
    wrq(1, 8'h30, 32'h1, 4'hF);
    step();
    idle();
    wrq(1, 8'h30, 32'h2, 4'hF);
    rdq(2, 8'h30);
    collect(2, "rdw_old", 32'h1, 1'b1, 32'h1);
    rdq(2, 8'h30);
    collect(2, "rdw_new", 32'h2, 1'b1, 32'h2);

    // Same-port read+write is a write with no read response.
    wrq(1, 8'h30, 32'h3, 4'hF);
    read = 1;
    step();
    idle();
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      nv += int'(rdv_a) + int'(rdv_b);
    end
    check("rw_novalid", 64'(nv), 64'h0);
    rdq(1, 8'h30);
    collect(1, "rw_write", 32'h3, 1'b1, 32'h3);

    // Same-word collision with partial lane overlap.
    wrq(1, 8'h40, 32'h12345678, 4'hF);
    step();
    idle();
    wrq(1, 8'h40, 32'hAAAAAAAA, 4'b0011);
    wrq(2, 8'h40, 32'hBBBBBBBB, 4'b0110);
    step();
    idle();
    check("col_pulse", 64'({col_a, col_b}), 64'h3);
    step();
    check("col_once", 64'({col_a, col_b}), 64'h0);
    rdq(1, 8'h40);
    collect(1, "col_data", 32'h12BBAAAA, 1'b1, 32'h12BBBBAA);

    // In-flight read discarded by reset.
    rdq(1, 8'h20);
    step();
    idle();
    reset = 1;
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      nv += int'(rdv_a) + int'(rdv_b);
    end
    check("flush_novalid", 64'(nv), 64'h0);

    // Reset partway through the clear restarts the full sweep.
    reset = 0;
    for (int c = 0; c < 100; c++) step();
    check("midclear_wait", 64'({wr_a, wr_b}), 64'h2);
    reset = 1;
    step();
    reset = 0;
    cnt = 0;
    while (wr_a && cnt < 1000) begin
      step();
      cnt++;
    end
    check("reclear_len", 64'(cnt), 64'd256);
    rdq(1, 8'h20);
    collect(1, "post_reset", 32'h0, 1'b1, 32'h11BB33DD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
